sel_code_decoder: RTL and testbench
===================================

// Module: sel_code_decoder
// PURPOSE
//  Receive end of the 2-bit select-code interface. Accepts 2-bit codes over valid/ready,
//  decodes each legal code to a 3-bit one-hot, buffers results in a DEPTH-entry FIFO and
//  presents them downstream over valid/ready. Code 2'b11 is illegal on this link: it is
//  flagged with a sticky error and dropped. Sits between the code source and the consumer.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >= 2
//  CNT_W   8   width of each statistics counter (used only with SEL_DEC_STATS_EN)
// PORTS
//  clk         in   1                   single clock, all logic on rising edge
//  rst         in   1                   synchronous, active-high reset
//  in_code     in   2                   encoded select code
//  in_valid    in   1                   in_code valid this cycle
//  in_ready    out  1                   block can accept a code this cycle
//  out_onehot  out  3                   decoded head-of-FIFO value
//  out_valid   out  1                   out_onehot valid
//  out_ready   in   1                   consumer takes out_onehot this cycle
//  err         out  1                   sticky: an illegal code (2'b11) was accepted
//  err_clr     in   1                   clears err
//  level       out  $clog2(DEPTH)+1     current FIFO occupancy, 0..DEPTH
//  cnt_00/01/10 out CNT_W each          accepted-code counters (SEL_DEC_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): wr/rd pointers=0, level=0, out_valid=0, out_onehot=3'b000,
//    err=0, counters=0; FIFO contents discarded. in_ready=0 while rst is high, 1 the cycle after.
//  - Reset mid-transfer: any entries held are lost; no output beat after reset until new input.
//  - Input accept: in_valid & in_ready. in_ready = (level != DEPTH); it never depends on out_ready.
//  - Decode at write: 2'b00->3'b001, 2'b01->3'b010, 2'b10->3'b100.
//  - 2'b11: accepted (consumes the beat), NOT written to FIFO, err=1 from the next cycle.
//  - err_clr=1 clears err next cycle; illegal accept in same cycle as err_clr -> err stays 1.
//  - Output: out_valid = (level != 0); out_onehot = FIFO head when valid, else 3'b000.
//    Pop on out_valid & out_ready. out_onehot/out_valid held stable until popped.
//  - Latency: legal code accepted at edge N with FIFO empty -> out_valid=1 after edge N (1 cycle).
//  - Simultaneous legal push + pop: level unchanged, order preserved (FIFO, no reordering).
//  - Full: in_ready=0; a pop that cycle frees space, in_ready=1 on the following cycle.
//  - Empty: pop request ignored (out_valid=0); push proceeds normally.
//  - Pointers wrap modulo DEPTH; level never exceeds DEPTH nor goes below 0.
//  - All outputs except in_ready/out_valid/out_onehot driven directly from registers;
//    those three are decoded only from registered state (level, head entry).
// CONFIGURATION
//  - SEL_DEC_STATS_EN defined: ports cnt_00, cnt_01, cnt_10 present; each increments by 1 on
//    every accepted code of that value, saturates at all-ones, cleared only by rst.
//    Illegal 2'b11 is counted by none.
//  - SEL_DEC_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1 Reset: rst=1 two cycles -> in_ready=0, out_valid=0, out_onehot=000, level=0, err=0; after
//    release in_ready=1.
//  2 Single beat: push 2'b01, out_ready=1 -> next cycle out_valid=1, out_onehot=3'b010, then
//    popped; level back to 0.
//  3 Fill/backpressure (DEPTH=4, out_ready=0): push 00,01,10,00 -> level=4, in_ready=0; 5th beat
//    held by source; release out_ready -> outputs 001,010,100,001 in order, 5th beat then accepted.
//  4 Illegal code: push 2'b11 -> level unchanged, err=1 next cycle; err_clr=1 with another 2'b11
//    same cycle -> err stays 1; err_clr alone -> err=0.
//  5 Streaming: level=2, in_valid=1 and out_ready=1 for 10 cycles with legal codes -> level stays
//    2, output sequence equals input sequence delayed by 2 beats.
//  6 Reset mid-stream with level=3 -> level=0, out_valid=0 next cycle; with SEL_DEC_STATS_EN,
//    push 2'b10 x 300 with CNT_W=8 -> cnt_10=255 (saturated), cnt_00=cnt_01=0.

Source files
------------

// File: rtl/sel_code_decoder.sv
// sel_code_decoder: receive end of the 2-bit select-code link. Decodes legal codes
//   to a 3-bit one-hot and queues them in a DEPTH-entry FIFO. Latency is 1 cycle
//   from input accept to out_valid when the FIFO is empty.
// Backpressure: in_ready drops only when the FIFO is full and never looks at out_ready.
//   Code 2'b11 is consumed, flagged on the sticky err and not queued.
// Ports: clk/rst (synchronous, active-high); in_code/in_valid/in_ready is the code
//   input; out_onehot/out_valid/out_ready is the decoded output; err/err_clr is the
//   illegal-code flag; level is the FIFO occupancy.
// Optional: define SEL_DEC_STATS_EN to add the saturating cnt_00/cnt_01/cnt_10
//   per-code accept counters.
module sel_code_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 in_code,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [2:0]                 out_onehot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       err,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     level
`ifdef SEL_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0]           cnt_00,
  output logic [CNT_W-1:0]           cnt_01,
  output logic [CNT_W-1:0]           cnt_10
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  // Low during reset and for the first edge after it, so in_ready comes only from
  // registered state.
  logic          ready_en;

  logic          accept;
  logic          illegal;
  logic          push;
  logic          pop;
  logic [2:0]    dec;

  assign in_ready   = ready_en && (level != LW'(DEPTH));
  assign out_valid  = (level != '0);
  assign out_onehot = out_valid ? mem[rd_ptr] : 3'b000;

  assign accept  = in_valid && in_ready;
  assign illegal = accept && (in_code == 2'b11);
  assign push    = accept && (in_code != 2'b11);
  assign pop     = out_valid && out_ready;

  always_comb begin
    dec = 3'b000;
    case (in_code)
      2'b00:   dec = 3'b001;
      2'b01:   dec = 3'b010;
      2'b10:   dec = 3'b100;
      default: dec = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // A push and a pop in the same cycle leave the occupancy unchanged.
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
    end
  end

  // An illegal accept takes priority over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (illegal)
      err <= 1'b1;
    else if (err_clr)
      err <= 1'b0;
  end

`ifdef SEL_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_00 <= '0;
      cnt_01 <= '0;
      cnt_10 <= '0;
    end else if (accept) begin
      if (in_code == 2'b00 && cnt_00 != '1) cnt_00 <= cnt_00 + 1'b1;
      if (in_code == 2'b01 && cnt_01 != '1) cnt_01 <= cnt_01 + 1'b1;
      if (in_code == 2'b10 && cnt_10 != '1) cnt_10 <= cnt_10 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sel_code_decoder.sv
// tb_sel_code_decoder: directed test of sel_code_decoder with DEPTH=4, CNT_W=8.
//   Covers reset, a single beat, fill/backpressure, illegal codes, streaming and
//   reset mid-stream. With SEL_DEC_STATS_EN it also covers counter saturation.
module tb_sel_code_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       err_clr;
  logic [2:0] level;
`ifdef SEL_DEC_STATS_EN
  logic [7:0] cnt_00, cnt_01, cnt_10;
`endif

  int checks   = 0;
  int failures = 0;

  sel_code_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err),
    .err_clr    (err_clr),
    .level      (level)
`ifdef SEL_DEC_STATS_EN
    ,
    .cnt_00     (cnt_00),
    .cnt_01     (cnt_01),
    .cnt_10     (cnt_10)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] onehot_of(input logic [1:0] c);
    case (c)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  logic [1:0] stream_codes [10] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01,
                                    2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
  logic [2:0] exp_q [$];

  initial begin
    rst = 1'b1; in_code = 2'b00; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

    // 1 reset
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // 2 single beat
    in_valid = 1'b1; in_code = 2'b01; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_onehot", out_onehot, 3'b010);
    chk("single_level1", level, 1);
    step();
    chk("single_level0", level, 0);
    chk("single_drained", out_valid, 0);

    // 3 fill and backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    in_code = 2'b00; step();
    in_code = 2'b01; step();
    in_code = 2'b10; step();
    in_code = 2'b00; step();
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    in_code = 2'b01; step();
    chk("full_hold_level", level, 4);
    out_ready = 1'b1;
    chk("drain0", out_onehot, 3'b001);
    step();
    chk("drain_in_ready", in_ready, 1);
    chk("drain1", out_onehot, 3'b010);
    step();
    in_valid = 1'b0;
    chk("drain_level3", level, 3);
    chk("drain2", out_onehot, 3'b100);
    step();
    chk("drain3", out_onehot, 3'b001);
    step();
    chk("drain4_fifth", out_onehot, 3'b010);
    step();
    chk("drain_level0", level, 0);
    chk("drain_empty", out_valid, 0);

    // 4 illegal code
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'b11;
    step();
    in_valid = 1'b0;
    chk("ill_level", level, 0);
    chk("ill_err", err, 1);
    in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("ill_clr_collide", err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ill_clr", err, 0);

    // 5 streaming at level 2
    in_valid = 1'b1;
    in_code = 2'b00; step(); exp_q.push_back(3'b001);
    in_code = 2'b10; step(); exp_q.push_back(3'b100);
    chk("stream_pre_level", level, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = stream_codes[i];
      chk($sformatf("stream_out%0d", i), out_onehot, exp_q.pop_front());
      exp_q.push_back(onehot_of(stream_codes[i]));
      step();
      chk($sformatf("stream_level%0d", i), level, 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // 6 reset mid-stream
    in_valid = 1'b1; in_code = 2'b00; step(); in_valid = 1'b0;
    chk("mid_level3", level, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    chk("mid_no_beat", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
`ifdef SEL_DEC_STATS_EN
    in_valid = 1'b1; in_code = 2'b10;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    chk("cnt_10_sat", cnt_10, 255);
    chk("cnt_00_zero", cnt_00, 0);
    chk("cnt_01_zero", cnt_01, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
